// File: rtl/float_pkg.sv
// Shared definitions for the compact float (sign, exponent, significand) encoder/decoder pair.
package float_pkg;

  localparam int EXP_W_DFLT = 3;
  localparam int SIG_W_DFLT = 4;
  localparam int OUT_W_DFLT = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } dec_state_t;

  typedef struct packed {
    logic                  sign;
    logic [EXP_W_DFLT-1:0] exp;
    logic [SIG_W_DFLT-1:0] sig;
  } float_t;

endpackage

// File: rtl/sm_to_twos.sv
// Combinational sign + magnitude to two's complement; a negative zero collapses to plain zero.
module sm_to_twos #(
  parameter int W = 12
) (
  input  logic         sign,
  input  logic [W-1:0] mag,
  output logic [W-1:0] data
);

  always_comb begin
    data = mag;
    if (sign && (mag != '0)) data = ~mag + W'(1);
  end

endmodule

// File: rtl/float_to_twos.sv
// Serial compact-float decoder: one left shift per cycle, valid/ready on both sides.
module float_to_twos
  import float_pkg::*;
#(
  parameter int EXP_W = EXP_W_DFLT,
  parameter int SIG_W = SIG_W_DFLT,
  parameter int OUT_W = OUT_W_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [SIG_W-1:0] in_sig,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_unnorm
);

  // The largest shifted significand must leave the top bit free for the sign.
  if (SIG_W + 2**EXP_W - 1 > OUT_W - 1) begin : g_width_check
    $error("float_to_twos: SIG_W + 2**EXP_W - 1 must not exceed OUT_W - 1");
  end

  dec_state_t       state;
  logic             sign_q;
  logic             unnorm_q;
  logic [OUT_W-1:0] mag;
  logic [EXP_W-1:0] cnt;
  logic [OUT_W-1:0] twos;

  assign in_ready = (state == IDLE);

  sm_to_twos #(.W(OUT_W)) u_sm_to_twos (
    .sign (sign_q),
    .mag  (mag),
    .data (twos)
  );

  // NOTE: every register here uses <= so all updates see the pre-edge values of mag/cnt/state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: reset clears the datapath too, so an aborted word never leaks a stale magnitude.
      state      <= IDLE;
      sign_q     <= 1'b0;
      unnorm_q   <= 1'b0;
      mag        <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_unnorm <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sign_q   <= in_sign;
            mag      <= {{(OUT_W-SIG_W){1'b0}}, in_sig};
            cnt      <= in_exp;
            unnorm_q <= (in_exp != '0) && !in_sig[SIG_W-1];
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            mag <= mag << 1;
            cnt <= cnt - EXP_W'(1);
          end else begin
            out_data   <= twos;
            out_unnorm <= unnorm_q;
            out_valid  <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          // out_data is deliberately left as-is after the handshake.
          if (out_ready && out_valid) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_twos.sv
// Bench for float_to_twos: arithmetic reference model, per-cycle comparison, directed and random words.
module tb_float_to_twos;
  import float_pkg::*;

  localparam int EXP_W = EXP_W_DFLT;
  localparam int SIG_W = SIG_W_DFLT;
  localparam int OUT_W = OUT_W_DFLT;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_sign = 1'b0;
  logic [EXP_W-1:0] in_exp = '0;
  logic [SIG_W-1:0] in_sig = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic             out_unnorm;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: expected handshake/output behaviour in cycle terms.
  bit m_busy = 0, m_valid = 0, m_unn = 0, p_unn = 0;
  int m_val = 0, p_val = 0, m_due = 0, cyc = 0, n_results = 0;

  always #5 clk = ~clk;

  float_to_twos #(.EXP_W(EXP_W), .SIG_W(SIG_W), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_sig     (in_sig),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_unnorm (out_unnorm)
  );

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, expv, expv, $time);
    end
  endtask

  function automatic int ref_value(bit s, int e, int f);
    int v;
    v = f * (1 << e);
    return s ? -v : v;
  endfunction

  function automatic bit ref_unnorm(int e, int f);
    return (e != 0) && (f < (1 << (SIG_W - 1)));
  endfunction

  always @(negedge rst_n) begin
    m_busy  = 0;
    m_valid = 0;
    m_val   = 0;
    m_unn   = 0;
  end

  // Model update on each edge, then comparison 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n) begin
        if (!m_busy && in_valid) begin
          m_busy = 1;
          m_due  = cyc + int'(in_exp) + 1;
          p_val  = ref_value(in_sign, int'(in_exp), int'(in_sig));
          p_unn  = ref_unnorm(int'(in_exp), int'(in_sig));
        end else if (m_valid && out_ready) begin
          m_valid = 0;
          m_busy  = 0;
          n_results++;
        end
        if (m_busy && !m_valid && cyc == m_due) begin
          m_valid = 1;
          m_val   = p_val;
          m_unn   = p_unn;
        end
      end
      #1;
      if (rst_n) begin
        check("cmp_in_ready", int'(in_ready), int'(!m_busy));
        check("cmp_out_valid", int'(out_valid), int'(m_valid));
        check("cmp_out_data", int'($signed(out_data)), m_val);
        check("cmp_out_unnorm", int'(out_unnorm), int'(m_unn));
      end
    end
  end

  // Called 2 units after an edge; returns 2 units after the accept edge.
  task automatic send_word(input bit s, input int e, input int f);
    logic ok;
    in_sign  = s;
    in_exp   = EXP_W'(e);
    in_sig   = SIG_W'(f);
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      ok = in_ready;
      @(posedge clk);
      #2;
      if (ok) begin
        in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // Counts edges until out_valid is seen; returns 1 unit after that edge (-1 on timeout).
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic take();
    #1 out_ready = 1'b1;
    @(posedge clk);
    #2 out_ready = 1'b0;
  endtask

  typedef struct {
    bit s;
    int e;
    int f;
    int data;
    bit unn;
    int lat;
  } vec_t;

  vec_t vecs[4] = '{
    '{0, 0, 5,  'h005, 0, 1},
    '{1, 7, 15, 'h880, 0, 8},
    '{1, 3, 0,  'h000, 1, 4},
    '{0, 2, 3,  'h00C, 1, 3}
  };

  initial begin
    int  lat;
    bit  acc_next;
    float_t w;

    #1 rst_n = 1'b0;
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_unnorm", int'(out_unnorm), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("reset_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #2;

    foreach (vecs[k]) begin
      w = '{sign: vecs[k].s, exp: EXP_W'(vecs[k].e), sig: SIG_W'(vecs[k].f)};
      send_word(w.sign, int'(w.exp), int'(w.sig));
      wait_valid(lat);
      check($sformatf("vec%0d_latency", k), lat, vecs[k].lat);
      check($sformatf("vec%0d_data", k), int'(out_data), vecs[k].data);
      check($sformatf("vec%0d_unnorm", k), int'(out_unnorm), int'(vecs[k].unn));
      take();
      #1 check($sformatf("vec%0d_valid_drop", k), int'(out_valid), 0);
      check($sformatf("vec%0d_data_kept", k), int'(out_data), vecs[k].data);
      @(posedge clk);
      #2;
    end

    // Backpressure with a second word waiting.
    send_word(0, 1, 8);
    wait_valid(lat);
    check("bp_first_data", int'(out_data), 'h010);
    #1;
    in_sign = 1'b0; in_exp = '0; in_sig = SIG_W'(1); in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_data_held", int'(out_data), 'h010);
      check("bp_in_ready_low", int'(in_ready), 0);
      check("bp_valid_held", int'(out_valid), 1);
    end
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 check("bp_ready_after_handshake", int'(in_ready), 1);
    check("bp_valid_after_handshake", int'(out_valid), 0);
    out_ready = 1'b0;
    @(posedge clk);
    #1 check("bp_second_accepted", int'(in_ready), 0);
    #1 in_valid = 1'b0;
    wait_valid(lat);
    check("bp_second_latency", lat, 1);
    check("bp_second_data", int'(out_data), 'h001);
    take();

    // Reset during the second SHIFT cycle of a long word.
    @(posedge clk);
    #2;
    send_word(1, 5, 9);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", int'(out_valid), 0);
    check("rst_mid_out_data", int'(out_data), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("rst_mid_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 check("rst_mid_no_result", int'(out_valid), 0);
    end

    // Random traffic with random consumer backpressure.
    acc_next = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #2;
      if (!in_valid || acc_next) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sign  = 1'($urandom_range(0, 1));
        in_exp   = EXP_W'($urandom_range(0, 2**EXP_W - 1));
        in_sig   = SIG_W'($urandom_range(0, 2**SIG_W - 1));
      end
      out_ready = 1'($urandom_range(0, 1));
      acc_next  = in_valid && in_ready;
    end
    @(posedge clk);
    #2;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    check("drain_idle", int'(in_ready), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
